// File: rtl/rrf_alloc.sv
// Rename-register-file tag allocator: hands out up to two tags per cycle in circular
// order, reclaims up to two per cycle at commit, and rewinds on flush.
module rrf_alloc #(
   parameter int RRF_NUM = 64,
   parameter int RRF_SEL = 6
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         req_num,
   input  logic               stall,
   input  logic               flush,
   input  logic [1:0]         com_num,
   output logic               alloc_ok,
   output logic [RRF_SEL-1:0] dpaddr1,
   output logic [RRF_SEL-1:0] dpaddr2,
   output logic               dpen1,
   output logic               dpen2,
   output logic [RRF_SEL-1:0] com1tag,
   output logic [RRF_SEL-1:0] com2tag,
   output logic [RRF_SEL:0]   freenum,
   output logic               rrf_full,
   output logic               rrf_empty,
   output logic               err_commit
);

   localparam logic [RRF_SEL:0] NUM_W = (RRF_SEL+1)'(RRF_NUM);

   logic [RRF_SEL-1:0] rrfptr_q, rrfptr_d;
   logic [RRF_SEL-1:0] comptr_q, comptr_d;
   logic [RRF_SEL:0]   freenum_q, freenum_d;
   logic               err_commit_q, err_commit_d;

   logic [1:0]         req;
   logic [1:0]         com_req;
   logic [1:0]         com_eff;
   logic [1:0]         alloc;
   logic [RRF_SEL:0]   occ;

   // Grant is all-or-nothing and uses the pre-update free count, so tags freed
   // this cycle only become grantable next cycle.
   always_comb begin
      req      = (req_num == 2'd3) ? 2'd2 : req_num;
      alloc_ok = reset & ~stall & ~flush & (req != 2'd0) &
                 (freenum_q >= (RRF_SEL+1)'(req));
      dpen1    = alloc_ok;
      dpen2    = alloc_ok & (req == 2'd2);
      alloc    = {1'b0, dpen1} + {1'b0, dpen2};
   end

   always_comb begin
      com_req = (com_num == 2'd3) ? 2'd2 : com_num;
      occ     = NUM_W - freenum_q;
      com_eff = (occ < (RRF_SEL+1)'(com_req)) ? occ[1:0] : com_req;
   end

   always_comb begin
      comptr_d     = comptr_q + RRF_SEL'(com_eff);
      err_commit_d = (com_eff != com_req);
      if (flush) begin
         rrfptr_d  = comptr_d;
         freenum_d = NUM_W;
      end else begin
         rrfptr_d  = rrfptr_q + RRF_SEL'(alloc);
         freenum_d = freenum_q - (RRF_SEL+1)'(alloc) + (RRF_SEL+1)'(com_eff);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rrfptr_q     <= '0;
         comptr_q     <= '0;
         freenum_q    <= NUM_W;
         err_commit_q <= 1'b0;
      end else begin
         rrfptr_q     <= rrfptr_d;
         comptr_q     <= comptr_d;
         freenum_q    <= freenum_d;
         err_commit_q <= err_commit_d;
      end
   end

   assign dpaddr1    = rrfptr_q;
   assign dpaddr2    = rrfptr_q + RRF_SEL'(1);
   assign com1tag    = comptr_q;
   assign com2tag    = comptr_q + RRF_SEL'(1);
   assign freenum    = freenum_q;
   assign rrf_full   = (freenum_q == '0);
   assign rrf_empty  = (freenum_q == NUM_W);
   assign err_commit = err_commit_q;

endmodule

// File: tb/tb_rrf_alloc.sv
// Bench for rrf_alloc: a behavioural model pushes expected outputs onto a queue
// each cycle; scenario tasks add directed checks on top.
module tb_rrf_alloc;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [1:0] req_num = 2'd0;
   logic       stall = 1'b0;
   logic       flush = 1'b0;
   logic [1:0] com_num = 2'd0;
   logic       alloc_ok, dpen1, dpen2, rrf_full, rrf_empty, err_commit;
   logic [5:0] dpaddr1, dpaddr2, com1tag, com2tag;
   logic [6:0] freenum;

   int checks = 0;
   int errors = 0;
   int m_rrf, m_com, m_free;
   bit m_err;
   logic [36:0] sb_q[$];

   rrf_alloc #(.RRF_NUM(64), .RRF_SEL(6)) dut (
      .clk(clk), .reset(reset), .req_num(req_num), .stall(stall), .flush(flush),
      .com_num(com_num), .alloc_ok(alloc_ok), .dpaddr1(dpaddr1), .dpaddr2(dpaddr2),
      .dpen1(dpen1), .dpen2(dpen2), .com1tag(com1tag), .com2tag(com2tag),
      .freenum(freenum), .rrf_full(rrf_full), .rrf_empty(rrf_empty),
      .err_commit(err_commit)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [36:0] dut_outs();
      return {alloc_ok, dpen1, dpen2, dpaddr1, dpaddr2, com1tag, com2tag,
              freenum, rrf_full, rrf_empty, err_commit};
   endfunction

   // One cycle: drive at negedge, push model expectation, score it, advance model.
   task automatic step(input int rn, input bit st, input bit fl, input int cn, input bit rs);
      int rq, cr, occ, ce, a;
      bit g;
      logic [36:0] e, got;
      @(negedge clk);
      req_num = 2'(rn);
      stall   = st;
      flush   = fl;
      com_num = 2'(cn);
      reset   = rs;
      rq  = (rn > 2) ? 2 : rn;
      g   = rs && !st && !fl && (rq != 0) && (m_free >= rq);
      a   = g ? rq : 0;
      occ = 64 - m_free;
      cr  = (cn > 2) ? 2 : cn;
      ce  = (cr < occ) ? cr : occ;
      sb_q.push_back({g, g, g && (rq == 2), 6'(m_rrf), 6'((m_rrf + 1) % 64),
                      6'(m_com), 6'((m_com + 1) % 64), 7'(m_free),
                      m_free == 0, m_free == 64, m_err});
      if (!rs) begin
         m_rrf = 0; m_com = 0; m_free = 64; m_err = 0;
      end else begin
         m_err = (ce < cr);
         m_com = (m_com + ce) % 64;
         if (fl) begin
            m_rrf  = m_com;
            m_free = 64;
         end else begin
            m_rrf  = (m_rrf + a) % 64;
            m_free = m_free - a + ce;
         end
      end
      #1;
      got = dut_outs();
      e = sb_q.pop_front();
      checks++;
      if (got !== e) begin
         errors++;
         $display("FAIL scoreboard t=%0t req=%0d com=%0d stall=%0b flush=%0b rst=%0b got=%h exp=%h",
                  $time, rn, cn, st, fl, rs, got, e);
      end
   endtask

   task automatic test_reset();
      reset   = 1'b0;
      req_num = 2'd2;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (alloc_ok !== 1'b0 || dpen1 !== 1'b0 || dpen2 !== 1'b0) begin
         errors++;
         $display("FAIL reset_grant_held got alloc_ok=%b dpen1=%b dpen2=%b exp 0 0 0",
                  alloc_ok, dpen1, dpen2);
      end
      m_rrf = 0; m_com = 0; m_free = 64; m_err = 0;
      step(0, 0, 0, 0, 1);
      checks++;
      if (freenum !== 7'd64 || rrf_empty !== 1'b1 || rrf_full !== 1'b0 || dpaddr1 !== 6'd0 ||
          com1tag !== 6'd0 || err_commit !== 1'b0) begin
         errors++;
         $display("FAIL reset_state got freenum=%0d empty=%b full=%b dpaddr1=%0d com1tag=%0d err=%b exp 64 1 0 0 0 0",
                  freenum, rrf_empty, rrf_full, dpaddr1, com1tag, err_commit);
      end
   endtask

   task automatic test_first_alloc();
      step(2, 0, 0, 0, 1);
      checks++;
      if (alloc_ok !== 1'b1 || dpaddr1 !== 6'd0 || dpaddr2 !== 6'd1 || dpen1 !== 1'b1 || dpen2 !== 1'b1) begin
         errors++;
         $display("FAIL first_alloc got ok=%b a1=%0d a2=%0d en=%b%b exp 1 0 1 11",
                  alloc_ok, dpaddr1, dpaddr2, dpen1, dpen2);
      end
      step(0, 0, 0, 0, 1);
      checks++;
      if (freenum !== 7'd62 || dpaddr1 !== 6'd2) begin
         errors++;
         $display("FAIL first_alloc_next got freenum=%0d rrfptr=%0d exp 62 2", freenum, dpaddr1);
      end
   endtask

   task automatic test_fill();
      repeat (31) step(2, 0, 0, 0, 1);
      step(1, 0, 0, 0, 1);
      checks++;
      if (freenum !== 7'd0 || rrf_full !== 1'b1 || alloc_ok !== 1'b0 || dpen1 !== 1'b0) begin
         errors++;
         $display("FAIL fill got freenum=%0d full=%b ok=%b dpen1=%b exp 0 1 0 0",
                  freenum, rrf_full, alloc_ok, dpen1);
      end
   endtask

   task automatic test_freenum_one();
      step(0, 0, 0, 1, 1);
      step(2, 0, 0, 0, 1);
      checks++;
      if (freenum !== 7'd1 || alloc_ok !== 1'b0) begin
         errors++;
         $display("FAIL no_partial_grant got freenum=%0d ok=%b exp 1 0", freenum, alloc_ok);
      end
      step(1, 0, 0, 0, 1);
      checks++;
      if (alloc_ok !== 1'b1 || dpen1 !== 1'b1 || dpen2 !== 1'b0) begin
         errors++;
         $display("FAIL single_grant got ok=%b en=%b%b exp 1 10", alloc_ok, dpen1, dpen2);
      end
      step(0, 0, 0, 1, 1);
      step(2, 0, 0, 2, 1);
      checks++;
      if (freenum !== 7'd1 || alloc_ok !== 1'b0) begin
         errors++;
         $display("FAIL free_same_cycle got freenum=%0d ok=%b exp 1 0", freenum, alloc_ok);
      end
      step(0, 0, 0, 0, 1);
      checks++;
      if (freenum !== 7'd3) begin
         errors++;
         $display("FAIL free_same_cycle_next got freenum=%0d exp 3", freenum);
      end
   endtask

   task automatic test_wrap();
      int guard;
      guard = 0;
      while (m_free < 64 && guard < 200) begin
         step(0, 0, 0, (64 - m_free) >= 2 ? 2 : 1, 1);
         guard++;
      end
      while (m_rrf != 63 && guard < 200) begin
         step((63 - m_rrf) >= 2 ? 2 : 1, 0, 0, (64 - m_free) >= 2 ? 2 : 0, 1);
         guard++;
      end
      checks++;
      if (guard >= 200) begin
         errors++;
         $display("FAIL wrap_setup got cycles=%0d exp under 200", guard);
      end
      step(2, 0, 0, 0, 1);
      checks++;
      if (alloc_ok !== 1'b1 || dpaddr1 !== 6'd63 || dpaddr2 !== 6'd0) begin
         errors++;
         $display("FAIL wrap got ok=%b a1=%0d a2=%0d exp 1 63 0", alloc_ok, dpaddr1, dpaddr2);
      end
      step(0, 0, 0, 0, 1);
      checks++;
      if (dpaddr1 !== 6'd1) begin
         errors++;
         $display("FAIL wrap_next got rrfptr=%0d exp 1", dpaddr1);
      end
   endtask

   task automatic test_flush();
      int guard, d, occ, cn;
      guard = 0;
      while (m_com != 10 && guard < 200) begin
         d   = (10 - m_com + 64) % 64;
         occ = 64 - m_free;
         cn  = 2;
         if (occ < cn) cn = occ;
         if (d < cn) cn = d;
         step(2, 0, 0, cn, 1);
         guard++;
      end
      checks++;
      if (guard >= 200) begin
         errors++;
         $display("FAIL flush_setup got cycles=%0d exp under 200", guard);
      end
      step(0, 0, 1, 0, 1);
      repeat (5) step(2, 0, 0, 0, 1);
      step(2, 0, 1, 2, 1);
      checks++;
      if (com1tag !== 6'd10 || dpaddr1 !== 6'd20 || alloc_ok !== 1'b0 || dpen1 !== 1'b0 || dpen2 !== 1'b0) begin
         errors++;
         $display("FAIL flush_cycle got com=%0d rrf=%0d ok=%b en=%b%b exp 10 20 0 00",
                  com1tag, dpaddr1, alloc_ok, dpen1, dpen2);
      end
      step(0, 0, 0, 0, 1);
      checks++;
      if (com1tag !== 6'd12 || dpaddr1 !== 6'd12 || freenum !== 7'd64) begin
         errors++;
         $display("FAIL flush_next got com=%0d rrf=%0d freenum=%0d exp 12 12 64",
                  com1tag, dpaddr1, freenum);
      end
   endtask

   task automatic test_overcommit();
      step(1, 0, 0, 0, 1);
      step(0, 0, 0, 2, 1);
      checks++;
      if (freenum !== 7'd63 || com1tag !== 6'd12 || err_commit !== 1'b0) begin
         errors++;
         $display("FAIL overcommit_pre got freenum=%0d com=%0d err=%b exp 63 12 0",
                  freenum, com1tag, err_commit);
      end
      step(0, 0, 0, 0, 1);
      checks++;
      if (com1tag !== 6'd13 || freenum !== 7'd64 || err_commit !== 1'b1) begin
         errors++;
         $display("FAIL overcommit got com=%0d freenum=%0d err=%b exp 13 64 1",
                  com1tag, freenum, err_commit);
      end
      step(0, 0, 0, 0, 1);
      checks++;
      if (err_commit !== 1'b0) begin
         errors++;
         $display("FAIL overcommit_pulse got err=%b exp 0", err_commit);
      end
   endtask

   task automatic test_reset_mid();
      repeat (3) step(2, 0, 0, 1, 1);
      step(2, 0, 0, 2, 0);
      checks++;
      if (alloc_ok !== 1'b0 || dpen1 !== 1'b0 || dpen2 !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_grant got ok=%b en=%b%b exp 0 00", alloc_ok, dpen1, dpen2);
      end
      step(0, 0, 0, 0, 1);
      checks++;
      if (dpaddr1 !== 6'd0 || com1tag !== 6'd0 || freenum !== 7'd64 || err_commit !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid got rrf=%0d com=%0d freenum=%0d err=%b exp 0 0 64 0",
                  dpaddr1, com1tag, freenum, err_commit);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3), $urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0,
              $urandom_range(0, 3), $urandom_range(0, 63) != 0);
      end
   endtask

   initial begin
      test_reset();
      test_first_alloc();
      test_fill();
      test_freenum_one();
      test_wrap();
      test_flush();
      test_overcommit();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
